fwd_hazard_unit: RTL and testbench

//  Generates the registered 2-bit operand selects that drive the EX-stage 4:1 operand muxes.

---
 rtl/fwd_hazard_unit_pkg.sv | 19 +
 rtl/fwd_hazard_unit_if.sv | 34 +++
 rtl/fwd_operand_select.sv | 28 ++
 rtl/fwd_hazard_unit.sv | 96 +++++++++
 tb/tb_fwd_hazard_unit.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the EX-stage forwarding / load-use hazard unit:
// operand-mux select codes, tracking-entry field layout and FSM encodings.
package fwd_hazard_unit_pkg;

    localparam logic [1:0] FWD_SEL_REGFILE = 2'b00;
    localparam logic [1:0] FWD_SEL_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_SEL_MEMWB   = 2'b10;

    // Tracking entry is {dest, valid, reg_write, mem_read}. The flags sit at the
    // LSB end so the dest field can follow the register-address width.
    localparam int ENT_MEM_READ  = 0;
    localparam int ENT_REG_WRITE = 1;
    localparam int ENT_VALID     = 2;
    localparam int ENT_NB_FLAGS  = 3;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_BUBBLE = 1'b1;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / EX-select response bundle between the pipeline and the
// forwarding-hazard unit.
interface fwd_hazard_unit_if #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_COUNT    = 16
);
    logic                   i_ext_stall;
    logic                   i_flush;
    logic                   i_id_valid;
    logic [NB_REG_ADDR-1:0] i_id_rs;
    logic [NB_REG_ADDR-1:0] i_id_rt;
    logic                   i_id_uses_rt;
    logic [NB_REG_ADDR-1:0] i_id_dest;
    logic                   i_id_reg_write;
    logic                   i_id_mem_read;
    logic                   o_stall;
    logic                   o_bubble;
    logic [1:0]             o_fwd_a_sel;
    logic [1:0]             o_fwd_b_sel;
    logic [NB_COUNT-1:0]    o_bubble_count;

    modport master (
        output i_ext_stall, i_flush, i_id_valid, i_id_rs, i_id_rt, i_id_uses_rt,
               i_id_dest, i_id_reg_write, i_id_mem_read,
        input  o_stall, o_bubble, o_fwd_a_sel, o_fwd_b_sel, o_bubble_count
    );

    modport slave (
        input  i_ext_stall, i_flush, i_id_valid, i_id_rs, i_id_rt, i_id_uses_rt,
               i_id_dest, i_id_reg_write, i_id_mem_read,
        output o_stall, o_bubble, o_fwd_a_sel, o_fwd_b_sel, o_bubble_count
    );

endinterface

// File: rtl/fwd_operand_select.sv
// Combinational select for one EX operand: compares a source address against
// the producers currently in EX and MEM; EX (youngest) wins.
module fwd_operand_select #(
    parameter int NB_REG_ADDR = 5
) (
    input  logic [NB_REG_ADDR-1:0] src,
    input  logic                   en,
    input  logic                   ex_valid,
    input  logic                   ex_reg_write,
    input  logic [NB_REG_ADDR-1:0] ex_dest,
    input  logic                   mem_valid,
    input  logic                   mem_reg_write,
    input  logic [NB_REG_ADDR-1:0] mem_dest,
    output logic [1:0]             sel,
    output logic                   ex_match
);
    import fwd_hazard_unit_pkg::*;

    logic mem_match;

    // $0 is hard-wired zero, so a producer "writing" it must never be forwarded.
    assign ex_match  = en && (src != '0) && ex_valid && ex_reg_write && (ex_dest == src);
    assign mem_match = en && (src != '0) && mem_valid && mem_reg_write && (mem_dest == src);

    assign sel = ex_match  ? FWD_SEL_EXMEM :
                 mem_match ? FWD_SEL_MEMWB : FWD_SEL_REGFILE;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit, advancing in lock-step with the
// ID/EX register: tracks EX/MEM/WB producers, registers operand selects, stalls once per load-use.
module fwd_hazard_unit #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_COUNT    = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    fwd_hazard_unit_if.slave bus
);
    import fwd_hazard_unit_pkg::*;

    localparam int                  NB_ENTRY  = NB_REG_ADDR + ENT_NB_FLAGS;
    localparam logic [NB_COUNT-1:0] COUNT_MAX = '1;

    logic [NB_ENTRY-1:0] ex_entry, mem_entry, wb_entry, id_entry;
    logic [0:0]          state;
    logic [1:0]          fwd_a_sel, fwd_b_sel, next_a_sel, next_b_sel;
    logic [NB_COUNT-1:0] bubble_count;
    logic                a_ex_match, b_ex_match;
    logic                hazard, stall, id_live;

    fwd_operand_select #(.NB_REG_ADDR(NB_REG_ADDR)) u_sel_a (
        .src           (bus.i_id_rs),
        .en            (1'b1),
        .ex_valid      (ex_entry[ENT_VALID]),
        .ex_reg_write  (ex_entry[ENT_REG_WRITE]),
        .ex_dest       (ex_entry[ENT_NB_FLAGS +: NB_REG_ADDR]),
        .mem_valid     (mem_entry[ENT_VALID]),
        .mem_reg_write (mem_entry[ENT_REG_WRITE]),
        .mem_dest      (mem_entry[ENT_NB_FLAGS +: NB_REG_ADDR]),
        .sel           (next_a_sel),
        .ex_match      (a_ex_match)
    );

    fwd_operand_select #(.NB_REG_ADDR(NB_REG_ADDR)) u_sel_b (
        .src           (bus.i_id_rt),
        .en            (bus.i_id_uses_rt),
        .ex_valid      (ex_entry[ENT_VALID]),
        .ex_reg_write  (ex_entry[ENT_REG_WRITE]),
        .ex_dest       (ex_entry[ENT_NB_FLAGS +: NB_REG_ADDR]),
        .mem_valid     (mem_entry[ENT_VALID]),
        .mem_reg_write (mem_entry[ENT_REG_WRITE]),
        .mem_dest      (mem_entry[ENT_NB_FLAGS +: NB_REG_ADDR]),
        .sel           (next_b_sel),
        .ex_match      (b_ex_match)
    );

    // A load in EX cannot be forwarded yet; the consumer waits one cycle and
    // then picks the value up from MEM/WB. A flushed instruction never stalls.
    assign hazard = bus.i_id_valid && !bus.i_flush && ex_entry[ENT_MEM_READ]
                    && (a_ex_match || b_ex_match);
    assign stall  = hazard && !bus.i_ext_stall;

    // Invalid entries are stored as all-zero so a bubble carries no stale flags.
    assign id_live  = bus.i_id_valid && !bus.i_flush && !stall;
    assign id_entry = id_live ? {bus.i_id_dest, 1'b1, bus.i_id_reg_write, bus.i_id_mem_read}
                              : '0;

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments let every stage sample the pre-edge
        // value of its neighbour, which is what makes the shift register work.
        if (i_reset) begin
            ex_entry     <= '0;
            mem_entry    <= '0;
            wb_entry     <= '0;
            fwd_a_sel    <= FWD_SEL_REGFILE;
            fwd_b_sel    <= FWD_SEL_REGFILE;
            state        <= ST_RUN;
            bubble_count <= '0;
        end else if (!bus.i_ext_stall) begin
            wb_entry  <= mem_entry;
            mem_entry <= ex_entry;
            ex_entry  <= id_entry;
            fwd_a_sel <= id_live ? next_a_sel : FWD_SEL_REGFILE;
            fwd_b_sel <= id_live ? next_b_sel : FWD_SEL_REGFILE;
            state     <= stall ? ST_BUBBLE : ST_RUN;
            if (stall && state == ST_RUN && bubble_count != COUNT_MAX)
                bubble_count <= bubble_count + 1'b1;
        end
    end

    assign bus.o_stall        = stall;
    assign bus.o_bubble       = stall;
    assign bus.o_fwd_a_sel    = fwd_a_sel;
    assign bus.o_fwd_b_sel    = fwd_b_sel;
    assign bus.o_bubble_count = bubble_count;

    // A bubble leaves EX empty, so back-to-back stalls are structurally impossible.
    a_no_stall_in_bubble: assert property (@(posedge i_clk) disable iff (i_reset)
        (state == ST_BUBBLE) |-> !stall);

    a_wb_empty_is_zero: assert property (@(posedge i_clk) disable iff (i_reset)
        !wb_entry[ENT_VALID] |-> (wb_entry == '0));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding paths, load-use stall, $0,
// flush/freeze priority, reset mid-bubble and counter saturation (narrow instance).
module tb_fwd_hazard_unit;
    import fwd_hazard_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.NB_REG_ADDR(5), .NB_COUNT(16)) bus ();
    fwd_hazard_unit_if #(.NB_REG_ADDR(5), .NB_COUNT(4))  sat_bus ();

    fwd_hazard_unit #(.NB_REG_ADDR(5), .NB_COUNT(16)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    fwd_hazard_unit #(.NB_REG_ADDR(5), .NB_COUNT(4)) dut_sat (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (sat_bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic use_rt, input logic [4:0] dest,
                          input logic rw, input logic mr);
        bus.i_id_valid     = v;
        bus.i_id_rs        = rs;
        bus.i_id_rt        = rt;
        bus.i_id_uses_rt   = use_rt;
        bus.i_id_dest      = dest;
        bus.i_id_reg_write = rw;
        bus.i_id_mem_read  = mr;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        bus.i_flush     = 1'b0;
        bus.i_ext_stall = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_sels(input string name, input logic [1:0] a, input logic [1:0] b);
        checks++;
        if (bus.o_fwd_a_sel !== a || bus.o_fwd_b_sel !== b) begin
            errors++;
            $display("FAIL %s: sels a=%b b=%b, expected a=%b b=%b",
                     name, bus.o_fwd_a_sel, bus.o_fwd_b_sel, a, b);
        end
    endtask

    task automatic chk_stall(input string name, input logic exp);
        checks++;
        if (bus.o_stall !== exp || bus.o_bubble !== exp) begin
            errors++;
            $display("FAIL %s: stall=%b bubble=%b, expected both %b",
                     name, bus.o_stall, bus.o_bubble, exp);
        end
    endtask

    task automatic chk_count(input string name, input logic [15:0] exp);
        checks++;
        if (bus.o_bubble_count !== exp) begin
            errors++;
            $display("FAIL %s: bubble_count=%0d, expected %0d", name, bus.o_bubble_count, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        sat_bus.i_ext_stall = 1'b0;
        sat_bus.i_flush     = 1'b0;
        sat_bus.i_id_valid  = 1'b0;
        sat_bus.i_id_rs     = '0;
        sat_bus.i_id_rt     = '0;
        sat_bus.i_id_uses_rt   = 1'b0;
        sat_bus.i_id_dest      = '0;
        sat_bus.i_id_reg_write = 1'b0;
        sat_bus.i_id_mem_read  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk_sels("reset_sels", 2'b00, 2'b00);
        chk_stall("reset_stall", 1'b0);
        chk_count("reset_count", 16'd0);
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5
    task automatic test_back_to_back();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        chk_sels("add_sels", 2'b00, 2'b00);
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
        settle();
        chk_stall("b2b_no_stall", 1'b0);
        tick();
        chk_sels("b2b_exmem", 2'b01, 2'b00);
    endtask

    // add $3 ; nop ; or $6,$7,$3   then   add $3 ; nop ; nop ; sub $12,$3,$3
    task automatic test_forward_memwb();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        set_id(1'b1, 5'd7, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
        tick();
        chk_sels("memwb_b", 2'b00, 2'b10);

        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd12, 1'b1, 1'b0);
        tick();
        chk_sels("wb_not_forwarded", 2'b00, 2'b00);
    endtask

    // add $3,$1,$2 ; add $3,$0,$0 ; and $10,$3,$3 ; addi $11,$3 (rt not a source)
    task automatic test_priority();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        chk_sels("ex_priority", 2'b01, 2'b01);
        set_id(1'b1, 5'd3, 5'd3, 1'b0, 5'd11, 1'b1, 1'b0);
        tick();
        chk_sels("uses_rt_gate", 2'b10, 2'b00);
    endtask

    // lw $8,0($0) ; add $9,$8,$8
    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd0, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        settle();
        chk_stall("lu_stall", 1'b1);
        tick();
        chk_sels("lu_bubble_sels", 2'b00, 2'b00);
        settle();
        chk_stall("lu_one_cycle", 1'b0);
        tick();
        chk_sels("lu_after_sels", 2'b10, 2'b10);
        chk_count("lu_count", 16'd1);

        set_id(1'b1, 5'd0, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
        settle();
        chk_stall("lu_rt_stall", 1'b1);
        set_id(1'b1, 5'd2, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0);
        settle();
        chk_stall("lu_rt_unused", 1'b0);
        idle();
        tick();
        chk_count("lu_count_hold", 16'd1);
    endtask

    // add $0,$1,$2 ; sub $5,$0,$0 ; lw $0 ; add $6,$0,$0
    task automatic test_zero_reg();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
        settle();
        chk_stall("zero_no_stall", 1'b0);
        tick();
        chk_sels("zero_sels", 2'b00, 2'b00);
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
        settle();
        chk_stall("zero_lw_no_stall", 1'b0);
        tick();
        chk_sels("zero_lw_sels", 2'b00, 2'b00);
        chk_count("zero_count", 16'd0);
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1'b1, 5'd0, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        bus.i_flush = 1'b1;
        settle();
        chk_stall("flush_no_stall", 1'b0);
        tick();
        bus.i_flush = 1'b0;
        chk_count("flush_count", 16'd0);
        chk_sels("flush_sels", 2'b00, 2'b00);
    endtask

    // add $1,$2,$3 ; lw $8,0($1) ; add $9,$8,$8 frozen for 3 cycles
    task automatic test_ext_stall();
        do_reset();
        set_id(1'b1, 5'd2, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd1, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        chk_sels("frz_pre_sels", 2'b01, 2'b00);
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        bus.i_ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_stall("frz_stall", 1'b0);
            tick();
            chk_sels("frz_sels", 2'b01, 2'b00);
        end
        chk_count("frz_count", 16'd0);
        bus.i_ext_stall = 1'b0;
        settle();
        chk_stall("frz_release_stall", 1'b1);
        tick();
        chk_count("frz_release_count", 16'd1);
        settle();
        chk_stall("frz_release_clear", 1'b0);
        tick();
        chk_sels("frz_release_sels", 2'b10, 2'b10);
    endtask

    task automatic test_reset_in_bubble();
        do_reset();
        set_id(1'b1, 5'd0, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        chk_count("rib_count_before", 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk_stall("rib_stall", 1'b0);
        chk_sels("rib_sels", 2'b00, 2'b00);
        chk_count("rib_count", 16'd0);
        tick();
        chk_sels("rib_mem_discarded", 2'b00, 2'b00);
    endtask

    // Repeated lw $8,0($8): one bubble every two edges on a 4-bit counter.
    task automatic test_saturation();
        do_reset();
        sat_bus.i_id_valid     = 1'b1;
        sat_bus.i_id_rs        = 5'd8;
        sat_bus.i_id_rt        = 5'd0;
        sat_bus.i_id_uses_rt   = 1'b0;
        sat_bus.i_id_dest      = 5'd8;
        sat_bus.i_id_reg_write = 1'b1;
        sat_bus.i_id_mem_read  = 1'b1;
        for (int i = 0; i < 28; i++) tick();
        checks++;
        if (sat_bus.o_bubble_count !== 4'd14) begin
            errors++;
            $display("FAIL sat_count_14: got %0d, expected 14", sat_bus.o_bubble_count);
        end
        for (int i = 0; i < 13; i++) tick();
        settle();
        checks++;
        if (sat_bus.o_stall !== 1'b1) begin
            errors++;
            $display("FAIL sat_still_stalls: stall=%b, expected 1", sat_bus.o_stall);
        end
        tick();
        checks++;
        if (sat_bus.o_bubble_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d, expected 15", sat_bus.o_bubble_count);
        end
        sat_bus.i_id_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_forward_memwb();
        test_priority();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_ext_stall();
        test_reset_in_bubble();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
